mps_op_seq: RTL
===============

// Module: mps_op_seq
// PURPOSE
//  Parametrised MPS power-on/power-off sequencer, the successor to the fixed 4-step operation FSM.
//  - Runs a configurable table of N_STEP on-steps; each step waits for an ext-DI bit or for the DC-link voltage.
//  - Each step is qualified by a programmable continuous-hold time and guarded by a per-step timeout.
//  - Runs a 3-stage off sequence with its own timeout.
//  - Sits between the MPS register map (flags, config) and the PSU control / interlock logic.
// PARAMETERS
//  N_STEP   5    number of on-sequence check steps (1..16)
//  DI_W     16   width of i_ext_di
//  V_W      32   signed fixed-point DC-link voltage width (replaces float compare IP)
//  HOLD_W   28   hold counter width (saturating)
//  TO_W     29   timeout counter width (saturating)
// PORTS
//  i_clk          in   1               system clock
//  i_rst          in   1               asynchronous, active-low reset
//  i_op_on_flag   in   1               1-cycle on request
//  i_op_off_flag  in   1               1-cycle off request
//  i_op_intl      in   1               level interlock
//  i_ext_di       in   DI_W            external digital inputs
//  i_dc_v         in   V_W             DC-link voltage, signed
//  i_v_on_th      in   V_W             voltage-step pass threshold (i_dc_v > th)
//  i_v_off_th     in   V_W             discharge pass threshold (i_dc_v < th)
//  i_step_sel     in   N_STEP*4        per-step DI bit index (bits [4k+3:4k])
//  i_step_pol     in   N_STEP          per-step required DI level
//  i_step_kind    in   N_STEP          0 = DI check, 1 = voltage check
//  i_hold         in   HOLD_W          qualify time in cycles (applies to all steps and MAIN_OFF)
//  i_timeout      in   TO_W            per-step timeout in cycles; 0 disables
//  o_on_phase     out  3               0 IDLE, 1 CLR, 2 CHK, 3 DONE, 4 SYS_ON, 7 FAIL
//  o_on_step      out  STEP_W          current step index k
//  o_off_state    out  2               0 IDLE, 1 MAIN_OFF, 2 DISCHA, 3 SYS_OFF
//  o_fail_step    out  STEP_W          latched k at last failure
//  o_fail_code    out  2               0 none, 1 interlock, 2 on-timeout, 3 off-timeout
//  o_sys_on       out  1               high while o_on_phase == SYS_ON
// BEHAVIOUR
//  - Reset: all outputs 0; phases IDLE; all counters 0.
//  - On FSM transitions:
//    - IDLE -> CLR on on_flag (ignored when not IDLE).
//    - CLR: clears fail latch and k=0; -> CHK next cycle.
//    - CHK(k) -> DONE(k) when cond(k) has been continuously true for i_hold+1 cycles.
//    - DONE(k) -> CHK(k+1), or -> SYS_ON if k == N_STEP-1.
//    - SYS_ON -> IDLE in the cycle after off FSM is in SYS_OFF.
//  - cond(k):
//    - kind 0: i_ext_di[sel_k] == pol_k (sel_k >= DI_W reads 0).
//    - kind 1: registered (i_dc_v > i_v_on_th), 1-cycle compare latency.
//  - Hold counter: clears on entry to CHK and whenever cond is false; saturates at all-ones.
//  - Timeout counter: clears on CHK entry; increments each CHK cycle.
//    - When == i_timeout (and i_timeout != 0): -> FAIL, code 2.
//  - Interlock: i_op_intl=1 in any on phase except IDLE -> FAIL, code 1 (priority over timeout/hold).
//    - Interlock in IDLE is ignored.
//  - FAIL lasts 1 cycle -> IDLE; held interlock does not re-enter FAIL from IDLE.
//  - Fail latch: o_fail_step/o_fail_code written on FAIL entry; held until next CLR or reset.
//  - Off FSM transitions:
//    - IDLE -> MAIN_OFF on off_flag.
//    - MAIN_OFF -> DISCHA after i_hold+1 cycles.
//    - DISCHA -> SYS_OFF on registered (i_dc_v < i_v_off_th).
//    - SYS_OFF -> IDLE after 1 cycle.
//  - Off timeout: applies in DISCHA only; expiry -> IDLE, code 3, fail_step = 0, o_sys_on unaffected.
//  - Off request while on FSM is in CLR/CHK/DONE: aborts the on sequence to IDLE at once (no fail code).
//  - on_flag and off_flag in the same cycle: off wins, on is dropped.
//  - Voltage arithmetic: signed two's-complement compares, no scaling.
//  - Reset mid-sequence: both FSMs return to IDLE asynchronously.
// STRUCTURE
//  - mps_op_seq_pkg:
//    - phase/off-state encodings
//    - fail codes
//    - STEP_W = (N_STEP>1) ? $clog2(N_STEP) : 1
//  - Sub-module mps_step_qual: hold + timeout counters.
//    - In: cond, restart, i_hold, i_timeout. Out: pass, expire.
//    - Instantiated once for the on FSM and once for the off FSM.
// TESTING
//  - Nominal: N_STEP=5, hold=3, timeout=100, cond true steps 0-4 -> SYS_ON after CLR + 5 x (CHK 4 cycles + DONE 1); o_fail_code=0.
//  - Glitch: DI drops for 1 cycle at hold count 2 -> hold restarts; CHK lasts 4 cycles after the glitch.
//  - Timeout: step 2 cond never true, timeout=50 -> FAIL after 50 CHK cycles; fail_step=2, code=2; IDLE next cycle.
//  - Interlock: i_op_intl pulse in DONE(1) -> FAIL next edge, code=1, step=1; intl held in IDLE keeps phase 0.
//  - Off: from SYS_ON, off_flag, v drops below th at 20 cycles -> MAIN_OFF 4, DISCHA, SYS_OFF, IDLE; sys_on low. Never drops with timeout=30 -> code 3.
//  - Edge cases:
//    - on+off in the same cycle -> stays IDLE, off runs.
//    - off during CHK(3) -> on IDLE.
//    - async reset mid-CHK -> all outputs 0.

Source files
------------

// File: rtl/mps_op_seq_pkg.sv
// Shared encodings for the MPS on/off sequencer: phase codes, off states, fail codes.
// Also provides the step-index width helper used by the top level.
package mps_op_seq_pkg;

  typedef enum logic [2:0] {
    ON_IDLE   = 3'd0,
    ON_CLR    = 3'd1,
    ON_CHK    = 3'd2,
    ON_DONE   = 3'd3,
    ON_SYS_ON = 3'd4,
    ON_FAIL   = 3'd7
  } on_phase_t;

  typedef enum logic [1:0] {
    OFF_IDLE    = 2'd0,
    OFF_MAIN    = 2'd1,
    OFF_DISCHA  = 2'd2,
    OFF_SYS_OFF = 2'd3
  } off_state_t;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_INTL   = 2'd1,
    FC_ON_TO  = 2'd2,
    FC_OFF_TO = 2'd3
  } fail_code_t;

  function automatic int step_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mps_step_qual.sv
// Hold/timeout qualifier: pass once cond held hold+1 cycles, expire after timeout active cycles.
// Latency: pass/expire are combinational from registered counts; no backpressure.
module mps_step_qual
  import mps_op_seq_pkg::*;
#(
  parameter int HOLD_W = 28,
  parameter int TO_W   = 29
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cond,
  input  logic              restart,
  input  logic [HOLD_W-1:0] hold,
  input  logic [TO_W-1:0]   timeout,
  output logic              pass,
  output logic              expire
);

  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_nxt;

  // to_nxt counts the current cycle, so expiry lands after exactly 'timeout' active cycles
  always_comb begin
    to_nxt = (&to_cnt) ? to_cnt : to_cnt + TO_W'(1);
    pass   = cond && (hold_cnt >= hold);
    expire = (timeout != '0) && (to_nxt == timeout);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else if (restart) begin
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (!cond)
        hold_cnt <= '0;
      else if (!(&hold_cnt))
        hold_cnt <= hold_cnt + HOLD_W'(1);
      to_cnt <= to_nxt;
    end
  end

endmodule

// File: rtl/mps_op_seq.sv
// MPS power sequencer: N_STEP qualified on-steps plus a 3-stage off sequence with fail latch.
// Latency: 1-cycle registered voltage compares; flags are single-cycle pulses, no backpressure.
module mps_op_seq
  import mps_op_seq_pkg::*;
#(
  parameter int N_STEP = 5,
  parameter int DI_W   = 16,
  parameter int V_W    = 32,
  parameter int HOLD_W = 28,
  parameter int TO_W   = 29
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_op_on_flag,
  input  logic                          i_op_off_flag,
  input  logic                          i_op_intl,
  input  logic [DI_W-1:0]               i_ext_di,
  input  logic signed [V_W-1:0]         i_dc_v,
  input  logic signed [V_W-1:0]         i_v_on_th,
  input  logic signed [V_W-1:0]         i_v_off_th,
  input  logic [N_STEP*4-1:0]           i_step_sel,
  input  logic [N_STEP-1:0]             i_step_pol,
  input  logic [N_STEP-1:0]             i_step_kind,
  input  logic [HOLD_W-1:0]             i_hold,
  input  logic [TO_W-1:0]               i_timeout,
  output logic [2:0]                    o_on_phase,
  output logic [step_w(N_STEP)-1:0]     o_on_step,
  output logic [1:0]                    o_off_state,
  output logic [step_w(N_STEP)-1:0]     o_fail_step,
  output logic [1:0]                    o_fail_code,
  output logic                          o_sys_on
);

  localparam int SW = step_w(N_STEP);
  localparam logic [SW-1:0] LAST = SW'(N_STEP - 1);

  on_phase_t   phase;
  off_state_t  off_st;
  fail_code_t  fail_code;
  logic [SW-1:0] step, fail_step;
  logic        sys_on, v_on_ok, v_off_ok;
  logic [3:0]  cur_sel;
  logic        cur_pol, cur_kind, di_bit, on_cond;
  logic        on_pass, on_expire, off_pass, off_expire;
  logic        off_cond, off_restart, off_to_evt;
  logic [TO_W-1:0] off_timeout;

  always_comb begin
    cur_sel  = '0;
    cur_pol  = 1'b0;
    cur_kind = 1'b0;
    for (int i = 0; i < N_STEP; i++) begin
      if (int'(step) == i) begin
        cur_sel  = i_step_sel[i*4 +: 4];
        cur_pol  = i_step_pol[i];
        cur_kind = i_step_kind[i];
      end
    end
    // Indices beyond the DI bus read as 0
    di_bit = 1'b0;
    for (int i = 0; i < DI_W; i++) begin
      if (int'(cur_sel) == i)
        di_bit = i_ext_di[i];
    end
    on_cond = cur_kind ? v_on_ok : (di_bit == cur_pol);

    off_cond    = (off_st == OFF_MAIN);
    off_restart = !(off_st == OFF_MAIN || off_st == OFF_DISCHA) || (off_st == OFF_MAIN && off_pass);
    off_timeout = (off_st == OFF_DISCHA) ? i_timeout : '0;
    off_to_evt  = (off_st == OFF_DISCHA) && !v_off_ok && off_expire;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      v_on_ok  <= 1'b0;
      v_off_ok <= 1'b0;
    end else begin
      v_on_ok  <= i_dc_v > i_v_on_th;
      v_off_ok <= i_dc_v < i_v_off_th;
    end
  end

  mps_step_qual #(.HOLD_W(HOLD_W), .TO_W(TO_W)) u_on_qual (
    .clk(i_clk), .rst_n(i_rst), .cond(on_cond), .restart(phase != ON_CHK),
    .hold(i_hold), .timeout(i_timeout), .pass(on_pass), .expire(on_expire)
  );

  mps_step_qual #(.HOLD_W(HOLD_W), .TO_W(TO_W)) u_off_qual (
    .clk(i_clk), .rst_n(i_rst), .cond(off_cond), .restart(off_restart),
    .hold(i_hold), .timeout(off_timeout), .pass(off_pass), .expire(off_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      off_st <= OFF_IDLE;
    end else begin
      case (off_st)
        OFF_IDLE:    if (i_op_off_flag) off_st <= OFF_MAIN;
        OFF_MAIN:    if (off_pass) off_st <= OFF_DISCHA;
        OFF_DISCHA:  if (v_off_ok) off_st <= OFF_SYS_OFF;
                     else if (off_expire) off_st <= OFF_IDLE;
        default:     off_st <= OFF_IDLE;
      endcase
    end
  end

  // On FSM also owns the fail latch; an on-side failure overrides a same-cycle off timeout
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      phase     <= ON_IDLE;
      step      <= '0;
      sys_on    <= 1'b0;
      fail_code <= FC_NONE;
      fail_step <= '0;
    end else begin
      if (off_to_evt) begin
        fail_code <= FC_OFF_TO;
        fail_step <= '0;
      end
      case (phase)
        ON_IDLE: if (i_op_on_flag && !i_op_off_flag) phase <= ON_CLR;
        ON_FAIL: phase <= ON_IDLE;
        default: begin
          if (i_op_intl) begin
            phase     <= ON_FAIL;
            fail_code <= FC_INTL;
            fail_step <= step;
            sys_on    <= 1'b0;
          end else if (i_op_off_flag && phase != ON_SYS_ON) begin
            phase <= ON_IDLE;
          end else begin
            case (phase)
              ON_CLR: begin
                step      <= '0;
                fail_code <= FC_NONE;
                fail_step <= '0;
                phase     <= ON_CHK;
              end
              ON_CHK: begin
                if (on_pass) begin
                  phase <= ON_DONE;
                end else if (on_expire) begin
                  phase     <= ON_FAIL;
                  fail_code <= FC_ON_TO;
                  fail_step <= step;
                end
              end
              ON_DONE: begin
                if (step == LAST) begin
                  phase  <= ON_SYS_ON;
                  sys_on <= 1'b1;
                end else begin
                  step  <= step + SW'(1);
                  phase <= ON_CHK;
                end
              end
              ON_SYS_ON: begin
                if (off_st == OFF_SYS_OFF) begin
                  phase  <= ON_IDLE;
                  sys_on <= 1'b0;
                end
              end
              default: phase <= ON_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign o_on_phase  = phase;
  assign o_on_step   = step;
  assign o_off_state = off_st;
  assign o_fail_step = fail_step;
  assign o_fail_code = fail_code;
  assign o_sys_on    = sys_on;

endmodule
